// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_pkg: shared FSM state, access source and mode constants for mem_access_ctrl
package mem_access_pkg;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_RADDR = 3'd2,
    ST_RWAIT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
  typedef enum logic {SRC_CPU = 1'b0, SRC_MAN = 1'b1} src_t;
  localparam logic MODE_CPU = 1'b0;
  localparam logic MODE_MAN = 1'b1;
endpackage

// File: rtl/key_sync_edge.sv
// key_sync_edge: 2-flop synchroniser for an active-low key, optional debounce (MAC_DEBOUNCE_EN), one-cycle press pulse
module key_sync_edge
`ifdef MAC_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYC = 16
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic fall
);
  logic s1_q, s2_q, prev_q, lvl;
  // synchroniser and previous-level register for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= key_n;
      s2_q   <= s1_q;
      prev_q <= lvl;
    end
`ifdef MAC_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic filt_q, filt_d;
  // filtered level follows the synchronised key only after a full run of differing samples
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) filt_d = s2_q;
      else cnt_d = cnt_q + CW'(1);
    end
  end
  // debounce counter and filtered level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif
  assign fall = prev_q & ~lvl;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: RAM access sequencer for CPU req/ack bus and manual key loading; MAC_DEBOUNCE_EN adds key debounce
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int READ_LAT = 1
`ifdef MAC_DEBOUNCE_EN
  , parameter int DEBOUNCE_CYC = 16
`endif
) (
  input  logic              SysClock,
  input  logic              ResetN,
  input  logic              Mode,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWData,
  output logic              CpuAck,
  output logic [DATA_W-1:0] RdData,
  input  logic              ManStep,
  input  logic              ManClear,
  input  logic              ManWe,
  input  logic [DATA_W-1:0] ManData,
  output logic [ADDR_W-1:0] ManAddr,
  output logic [ADDR_W-1:0] RamAddr,
  output logic [DATA_W-1:0] RamData,
  output logic              RamWren,
  input  logic [DATA_W-1:0] RamQ,
  output logic              Busy
);
  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);
  state_t state_q, state_d;
  src_t src_q, src_d;
  logic [1:0] lat_q, lat_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d, man_addr_q, man_addr_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d, rd_data_q, rd_data_d;
  logic clr_seen_q, clr_seen_d;
  logic step, clear, cpu_go, man_go, start_we;
`ifdef MAC_DEBOUNCE_EN
  key_sync_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (.clk(SysClock), .rst_n(ResetN), .key_n(ManStep), .fall(step));
  key_sync_edge #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clear (.clk(SysClock), .rst_n(ResetN), .key_n(ManClear), .fall(clear));
`else
  key_sync_edge u_step (.clk(SysClock), .rst_n(ResetN), .key_n(ManStep), .fall(step));
  key_sync_edge u_clear (.clk(SysClock), .rst_n(ResetN), .key_n(ManClear), .fall(clear));
`endif
  // next-state logic: accept a request in IDLE, sequence it, and maintain the manual address
  always_comb begin
    cpu_go     = state_q == ST_IDLE && Mode == MODE_CPU && CpuReq;
    man_go     = state_q == ST_IDLE && Mode == MODE_MAN && step && !clear;
    start_we   = cpu_go ? CpuWe : ManWe;
    state_d    = state_q;
    src_d      = src_q;
    lat_d      = lat_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    rd_data_d  = rd_data_q;
    man_addr_d = man_addr_q;
    clr_seen_d = state_q != ST_IDLE && (clr_seen_q || clear);
    case (state_q)
      ST_IDLE:
        if (cpu_go || man_go) begin
          src_d      = cpu_go ? SRC_CPU : SRC_MAN;
          ram_addr_d = cpu_go ? CpuAddr : man_addr_q;
          ram_data_d = start_we ? (cpu_go ? CpuWData : ManData) : ram_data_q;
          state_d    = start_we ? ST_WRITE : ST_RADDR;
        end
      ST_WRITE: state_d = ST_DONE;
      ST_RADDR: begin
        state_d = ST_RWAIT;
        lat_d   = '0;
      end
      ST_RWAIT:
        if (lat_q == LAT_LAST) begin
          rd_data_d = RamQ;
          state_d   = ST_DONE;
        end else lat_d = lat_q + 2'd1;
      ST_DONE: begin
        state_d    = ST_IDLE;
        man_addr_d = (src_q == SRC_MAN && !clr_seen_q) ? man_addr_q + ADDR_W'(1) : man_addr_q;
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) man_addr_d = '0;
  end
  // state and datapath registers; reset abandons any access in flight
  always_ff @(posedge SysClock or negedge ResetN)
    if (!ResetN) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_CPU;
      lat_q      <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      rd_data_q  <= '0;
      man_addr_q <= '0;
      clr_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      lat_q      <= lat_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      rd_data_q  <= rd_data_d;
      man_addr_q <= man_addr_d;
      clr_seen_q <= clr_seen_d;
    end
  assign RamWren = state_q == ST_WRITE;
  assign CpuAck  = state_q == ST_DONE && src_q == SRC_CPU;
  assign Busy    = state_q != ST_IDLE;
  assign RamAddr = ram_addr_q;
  assign RamData = ram_data_q;
  assign RdData  = rd_data_q;
  assign ManAddr = man_addr_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random stimulus checked every cycle against a transaction-level model
module tb_mem_access_ctrl;
  localparam int RL = 1;
  logic SysClock = 1'b0;
  logic ResetN = 1'b1;
  logic Mode = 1'b0, CpuReq = 1'b0, CpuWe = 1'b0, ManStep = 1'b1, ManClear = 1'b1, ManWe = 1'b0;
  logic [3:0] CpuAddr = '0;
  logic [7:0] CpuWData = '0, ManData = '0, RamQ = '0;
  logic CpuAck, Busy, RamWren;
  logic [7:0] RdData, RamData;
  logic [3:0] ManAddr, RamAddr;
  logic [7:0] ram [16] = '{default: 8'h00};
  int checks = 0, errors = 0;
  int wren_cnt = 0, ack_cnt = 0, start_cnt = 0;
  logic busy_d = 1'b0;
  bit cmp_en = 1'b0;
  logic [7:0] gm [16] = '{default: 8'h00};
  bit [3:0] hist [2];
  bit p [2];
  bit [1:0] raw;
`ifdef MAC_DEBOUNCE_EN
  localparam int DB = 16;
  bit filt [2], prevl [2], lastv [2];
  int run [2];
`endif
  bit m_act = 1'b0, m_wr = 1'b0, m_man = 1'b0, m_clr = 1'b0;
  int m_k = 0, m_dur = 0;
  logic [3:0] m_addr = '0, e_addr = '0, e_man = '0;
  logic [7:0] e_data = '0, e_rd = '0;

  always #5 SysClock = ~SysClock;

  mem_access_ctrl dut (
    .SysClock(SysClock), .ResetN(ResetN), .Mode(Mode), .CpuReq(CpuReq), .CpuWe(CpuWe),
    .CpuAddr(CpuAddr), .CpuWData(CpuWData), .CpuAck(CpuAck), .RdData(RdData),
    .ManStep(ManStep), .ManClear(ManClear), .ManWe(ManWe), .ManData(ManData), .ManAddr(ManAddr),
    .RamAddr(RamAddr), .RamData(RamData), .RamWren(RamWren), .RamQ(RamQ), .Busy(Busy)
  );

  // synchronous RAM with one edge of read latency
  always @(posedge SysClock) begin
    if (RamWren === 1'b1) ram[RamAddr] <= RamData;
    RamQ <= ram[RamAddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_start(input bit man, input bit we, input logic [3:0] a, input logic [7:0] d);
    m_act  = 1'b1;
    m_k    = 0;
    m_clr  = 1'b0;
    m_man  = man;
    m_wr   = we;
    m_addr = a;
    m_dur  = we ? 2 : RL + 2;
    e_addr = a;
    if (we) begin
      e_data = d;
      gm[a]  = d;
    end
  endfunction

  // model: key press detection from raw input history, then access timeline from start edge
  always @(posedge SysClock or negedge ResetN) begin
    if (!ResetN) begin
      for (int k = 0; k < 2; k++) begin
        hist[k] = '0;
`ifdef MAC_DEBOUNCE_EN
        filt[k] = 0; prevl[k] = 0; lastv[k] = 0; run[k] = 0;
`endif
      end
      m_act = 0; m_k = 0; e_addr = '0; e_data = '0; e_rd = '0; e_man = '0;
    end else begin
      raw = {ManClear, ManStep};
      for (int k = 0; k < 2; k++) begin
        hist[k] = {hist[k][2:0], raw[k]};
`ifdef MAC_DEBOUNCE_EN
        p[k] = prevl[k] & ~filt[k];
        prevl[k] = filt[k];
        run[k] = (hist[k][2] == lastv[k]) ? run[k] + 1 : 1;
        lastv[k] = hist[k][2];
        if (hist[k][2] != filt[k] && run[k] >= DB) filt[k] = hist[k][2];
`else
        p[k] = hist[k][3] & ~hist[k][2];
`endif
      end
      if (m_act) begin
        m_k++;
        if (p[1]) m_clr = 1'b1;
        if (!m_wr && m_k == RL + 1) e_rd = gm[m_addr];
        if (m_k == m_dur) begin
          m_act = 1'b0;
          if (m_man && !m_clr) e_man = e_man + 4'd1;
        end
      end else if (Mode == 1'b0 && CpuReq) m_start(1'b0, CpuWe, CpuAddr, CpuWData);
      else if (Mode == 1'b1 && p[0] && !p[1]) m_start(1'b1, ManWe, e_man, ManData);
      if (p[1]) e_man = '0;
    end
  end

  // compare every output against the model each cycle
  always @(negedge SysClock) if (cmp_en) begin
    chk("Busy", Busy, m_act);
    chk("RamWren", RamWren, m_act && m_wr && m_k == 0);
    chk("CpuAck", CpuAck, m_act && !m_man && m_k == m_dur - 1);
    chk("RamAddr", RamAddr, e_addr);
    chk("RamData", RamData, e_data);
    chk("RdData", RdData, e_rd);
    chk("ManAddr", ManAddr, e_man);
  end

  // event counters used by the directed checks
  always @(negedge SysClock) begin
    if (RamWren === 1'b1) wren_cnt++;
    if (CpuAck === 1'b1) ack_cnt++;
    if (Busy === 1'b1 && busy_d !== 1'b1) start_cnt++;
    busy_d = Busy;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge SysClock);
  endtask

  task automatic press(input bit clr, input bit stp, input int lo, input int hi);
    ManClear = !clr;
    ManStep  = !stp;
    cyc(lo);
    ManClear = 1'b1;
    ManStep  = 1'b1;
    cyc(hi);
  endtask

  task automatic cpu(input bit we, input logic [3:0] a, input logic [7:0] d, output int lat);
    CpuWe = we; CpuAddr = a; CpuWData = d; CpuReq = 1'b1; lat = 0;
    do begin
      cyc(1);
      lat++;
    end while (CpuAck !== 1'b1 && lat < 20);
    CpuReq = 1'b0;
  endtask

  initial begin
    int lat, w0, a0, s0;
    #1 ResetN = 1'b0;
    #1 cmp_en = 1'b1;
    cyc(2);
    #2 ResetN = 1'b1;
    cyc(30);
    // reset during RWAIT
    CpuWe = 1'b0; CpuAddr = 4'd7; CpuReq = 1'b1;
    cyc(2);
    chk("t1_busy_rwait", Busy, 1);
    #2 ResetN = 1'b0;
    CpuReq = 1'b0;
    a0 = ack_cnt;
    cyc(1);
    chk("t1_rst_busy", Busy, 0);
    chk("t1_rst_ack", CpuAck, 0);
    chk("t1_rst_rd", RdData, 0);
    chk("t1_rst_addr", RamAddr, 0);
    cyc(1);
    #2 ResetN = 1'b1;
    cyc(3);
    chk("t1_idle", Busy, 0);
    chk("t1_no_ack", ack_cnt, a0);
    cyc(30);
    // CPU write then read
    w0 = wren_cnt;
    cpu(1'b1, 4'd3, 8'hA5, lat);
    chk("t2_wr_lat", lat, 2);
    chk("t2_wren_cnt", wren_cnt - w0, 1);
    chk("t2_ramaddr", RamAddr, 3);
    chk("t2_ramdata", RamData, 8'hA5);
    cyc(1);
    cpu(1'b0, 4'd3, 8'h00, lat);
    chk("t2_rd_lat", lat, 3);
    chk("t2_rddata", RdData, 8'hA5);
    // manual load of 17 words with wrap
    Mode = 1'b1; ManWe = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ManData = 8'(i);
      press(1'b0, 1'b1, 24, 24);
      if (i == 15) chk("t3_wrap", ManAddr, 0);
    end
    chk("t3_manaddr", ManAddr, 1);
    chk("t3_ram0", ram[0], 8'h10);
    chk("t3_ram9", ram[9], 8'h09);
    chk("t3_ram15", ram[15], 8'h0F);
    chk("t3_model_ram0", gm[0], 8'h10);
    // clear coinciding with step at address 5
    for (int i = 0; i < 4; i++) begin
      ManData = 8'(8'h20 + i);
      press(1'b0, 1'b1, 24, 24);
    end
    chk("t4_addr5", ManAddr, 5);
    w0 = wren_cnt;
    press(1'b1, 1'b1, 24, 24);
    chk("t4_cleared", ManAddr, 0);
    chk("t4_no_write", wren_cnt - w0, 0);
    // mode switch during a CPU read
    Mode = 1'b0;
    cyc(2);
    CpuWe = 1'b0; CpuAddr = 4'd9; CpuReq = 1'b1;
    cyc(1);
    Mode = 1'b1;
    lat = 1;
    while (CpuAck !== 1'b1 && lat < 20) begin
      cyc(1);
      lat++;
    end
    CpuReq = 1'b0;
    chk("t5_lat", lat, 3);
    chk("t5_rd", RdData, 8'h09);
    cyc(2);
    a0 = ack_cnt; s0 = start_cnt;
    CpuWe = 1'b1; CpuReq = 1'b1;
    cyc(10);
    chk("t5_no_ack", ack_cnt - a0, 0);
    chk("t5_no_busy", start_cnt - s0, 0);
    CpuReq = 1'b0;
    // short glitch and real press
    ManWe = 1'b0;
    s0 = start_cnt;
    press(1'b0, 1'b1, 10, 30);
`ifdef MAC_DEBOUNCE_EN
    chk("t6_glitch", start_cnt - s0, 0);
`else
    chk("t6_glitch", start_cnt - s0, 1);
`endif
    s0 = start_cnt;
    press(1'b0, 1'b1, 20, 30);
    chk("t6_press", start_cnt - s0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) Mode = ~Mode;
      if (CpuReq && CpuAck === 1'b1) CpuReq = 1'b0;
      else if (!CpuReq && $urandom_range(0, 3) == 0) begin
        CpuReq = 1'b1;
        CpuWe = 1'($urandom);
        CpuAddr = 4'($urandom);
        CpuWData = 8'($urandom);
      end else if (CpuReq && Mode && $urandom_range(0, 7) == 0) CpuReq = 1'b0;
      if ($urandom_range(0, 11) == 0) ManStep = ~ManStep;
      if ($urandom_range(0, 39) == 0) ManClear = ~ManClear;
      ManWe = 1'($urandom);
      ManData = 8'($urandom);
      cyc(1);
    end
    CpuReq = 1'b0; ManStep = 1'b1; ManClear = 1'b1;
    cyc(10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
